// File: rtl/z80_bus_ctrl.sv
// Bus controller for the fz80 core: decodes each CPU cycle, drives ROM/RAM/SIO strobes,
// stretches the cycle with cpu_wait and registers the read data returned to the CPU.
module z80_bus_ctrl #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 2,
  parameter int unsigned IO_WAIT  = 1,
  parameter logic [7:0]  SIO_BASE = 8'h84,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cpu_mreq,
  input  logic        cpu_iorq,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  output logic        cpu_wait,
  output logic [7:0]  cpu_rdata,
  output logic        rom_ce,
  output logic        ram_rden,
  output logic        ram_wren,
  output logic        sio_ce,
  output logic        sio_rd,
  output logic        sio_wr,
  input  logic [7:0]  rom_q,
  input  logic [7:0]  ram_q,
  input  logic [7:0]  sio_q,
  output logic        bus_err
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_CAPTURE, S_HOLD} state_e;
  typedef enum logic [1:0] {R_ROM, R_RAM, R_SIO, R_UNMAP} region_e;

  localparam int CNT_W = 8;

  state_e           state_q, state_d;
  region_e          region_q, region_d, region_dec;
  logic             wr_q, wr_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       rd_mux;
  logic             req, illegal;
  logic             unused_addr;

  assign req         = (cpu_mreq | cpu_iorq) & (cpu_rd | cpu_wr);
  assign illegal     = (cpu_mreq & cpu_iorq) | (cpu_rd & cpu_wr);
  assign unused_addr = ^{cpu_addr[14:8], cpu_addr[0]};

  function automatic logic [CNT_W-1:0] wait_for(input region_e r);
    case (r)
      R_ROM:   return CNT_W'(ROM_WAIT);
      R_RAM:   return CNT_W'(RAM_WAIT);
      R_SIO:   return CNT_W'(IO_WAIT);
      default: return CNT_W'(1);
    endcase
  endfunction

  always_comb begin
    region_dec = R_UNMAP;
    if (!illegal) begin
      if (cpu_mreq) begin
        region_dec = cpu_addr[15] ? R_RAM : R_ROM;
      end else if (cpu_addr[7:1] == SIO_BASE[7:1]) begin
        region_dec = R_SIO;
      end
    end
  end

  always_comb begin
    case (region_q)
      R_ROM:   rd_mux = rom_q;
      R_RAM:   rd_mux = ram_q;
      R_SIO:   rd_mux = sio_q;
      default: rd_mux = OPEN_BUS;
    endcase
  end

  // Every strobe is gated by req so an abandoned cycle releases the slaves at once.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    rdata_d  = rdata_q;
    rom_ce   = 1'b0;
    ram_rden = 1'b0;
    ram_wren = 1'b0;
    sio_ce   = 1'b0;
    sio_rd   = 1'b0;
    sio_wr   = 1'b0;
    bus_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          region_d = region_dec;
          wr_d     = cpu_wr & ~cpu_rd;
          cnt_d    = wait_for(region_dec);
          first_d  = 1'b1;
          bus_err  = illegal;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          rom_ce   = (region_q == R_ROM);
          ram_rden = (region_q == R_RAM) & ~wr_q;
          ram_wren = (region_q == R_RAM) & wr_q & first_q;
          sio_ce   = (region_q == R_SIO);
          sio_rd   = (region_q == R_SIO) & ~wr_q & first_q;
          sio_wr   = (region_q == R_SIO) & wr_q & first_q;
          if (cnt_q <= CNT_W'(1)) begin
            if (!wr_q) rdata_d = rd_mux;
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      region_q <= R_UNMAP;
      wr_q     <= 1'b0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= OPEN_BUS;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wr_q     <= wr_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Wait is asserted combinationally so the CPU sees it in the request's first clk.
  assign cpu_wait  = n_rst & req &
                     ((state_q == S_IDLE) | (state_q == S_SETUP) | (state_q == S_ACCESS));
  assign cpu_rdata = rdata_q;

endmodule
